// File: rtl/clk_div_pkg.sv
// Shared constants, divisor type and index-width helper for the multi-channel clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF       = 14;
  localparam int DEFAULT_DIV_DEF = 100;

  typedef logic [CNT_W_DEF-1:0] div_t;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, 50%-duty output, tick strobe and shadowed divisor.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             clk_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] div_active;
  logic [CNT_W-1:0] div_pend;
  logic             pend_vld;
  logic             terminal;

  // >= rather than == so a divisor shrunk below the running count still terminates
  assign terminal = en && (count >= div_active);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      clk_o      <= 1'b0;
      tick_o     <= 1'b0;
      div_active <= DIV_RST;
      div_pend   <= DIV_RST;
      pend_vld   <= 1'b0;
    end else begin
      if (sync) begin
        count  <= '0;
        clk_o  <= 1'b0;
        tick_o <= 1'b0;
        if (pend_vld) begin
          div_active <= div_pend;
          pend_vld   <= 1'b0;
        end
      end else if (terminal) begin
        count  <= '0;
        clk_o  <= ~clk_o;
        tick_o <= 1'b1;
        if (pend_vld) begin
          div_active <= div_pend;
          pend_vld   <= 1'b0;
        end
      end else if (en) begin
        count  <= count + CNT_W'(1);
        tick_o <= 1'b0;
      end else begin
        tick_o <= 1'b0;
      end

      // Placed last so a write in the same cycle as a load stays pending for next time
      if (load) begin
        div_pend <= load_val;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator with shadowed divisor writes.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                          clk_i,
  input  logic                          reset_n,
  input  logic                          en_i,
  input  logic                          sync_i,
  input  logic                          div_we_i,
  input  logic [ch_idx_w(NUM_CH)-1:0]   div_ch_i,
  input  logic [CNT_W-1:0]              div_val_i,
  output logic [NUM_CH-1:0]             clk_o,
  output logic [NUM_CH-1:0]             tick_o
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] load;

  // Indices with no matching channel decode to no strobe, so such writes vanish
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = div_we_i && (div_ch_i == IDX_W'(i));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i    (clk_i),
      .reset_n  (reset_n),
      .en       (en_i),
      .sync     (sync_i),
      .load     (load[i]),
      .load_val (div_val_i),
      .clk_o    (clk_o[i]),
      .tick_o   (tick_o[i])
    );
  end

endmodule
